// File: rtl/ram_sp_clr.sv
// Parameterised single-port synchronous RAM with a registered read port, a read-valid flag
// and a zero-fill clear engine that owns the memory for DEPTH cycles after reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | clear engine writes 0 to M[clr_addr] each cycle, busy=1
// ST_IDLE  | normal load/read access, busy=0, left only by reset
module ram_sp_clr #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  load,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    clearing;
    logic                    acc_load;
    logic                    acc_read;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Accesses are dropped while clearing and during reset cycles; nothing is queued.
    assign clearing  = (state == ST_CLEAR);
    assign acc_load  = resetn && (state == ST_IDLE) && load;
    assign acc_read  = resetn && (state == ST_IDLE) && read;

    // One shared write port keeps the array mappable onto a single BRAM.
    assign mem_we    = resetn && (clearing || acc_load);
    assign mem_waddr = clearing ? clr_addr : address;
    assign mem_wdata = clearing ? '0 : in;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Non-blocking read of mem gives old data on a same-cycle write (read-first).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= acc_read;
            if (acc_read) begin
                if ((WRITE_FIRST != 0) && acc_load) begin
                    out <= in;
                end else begin
                    out <= mem[address];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clr_addr <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state <= ST_CLEAR;
                busy  <= 1'b1;
            end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    busy     <= 1'b1;
                    if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: a default (read-first, clear-on-reset) build and a small write-first,
// no-clear build, each checked against a reference memory and a queue of expected read data.
module tb_ram_sp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Build A: 256x16, read-first, cleared on reset
    logic        a_resetn, a_load, a_read, a_valid, a_busy;
    logic [7:0]  a_addr;
    logic [15:0] a_in, a_out;

    // Build B: 16x8, write-first, no clear
    logic        b_resetn, b_load, b_read, b_valid, b_busy;
    logic [3:0]  b_addr;
    logic [7:0]  b_in, b_out;

    ram_sp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .resetn(a_resetn), .address(a_addr), .in(a_in), .load(a_load),
        .read(a_read), .out(a_out), .out_valid(a_valid), .busy(a_busy));

    ram_sp_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(1), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .resetn(b_resetn), .address(b_addr), .in(b_in), .load(b_load),
        .read(b_read), .out(b_out), .out_valid(b_valid), .busy(b_busy));

    int checks   = 0;
    int failures = 0;

    logic [15:0] ma [256];
    logic [15:0] qa [$];
    logic        a_busy_m;
    int          a_clr_cnt;
    logic [15:0] a_last;

    logic [7:0]  mb [16];
    logic [7:0]  qb [$];
    logic [7:0]  b_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_a(input int n);
        a_resetn = 1'b0; a_load = 1'b0; a_read = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("a_rst_out", {16'h0, a_out}, 32'h0);
            chk("a_rst_valid", {31'h0, a_valid}, 32'h0);
            chk("a_rst_busy", {31'h0, a_busy}, 32'h1);
        end
        a_resetn  = 1'b1;
        a_busy_m  = 1'b1;
        a_clr_cnt = 0;
        a_last    = 16'h0;
        qa.delete();
    endtask

    task automatic cyc_a(input bit ld, input bit rd, input logic [7:0] ad, input logic [15:0] d);
        bit acc;
        a_load = ld; a_read = rd; a_addr = ad; a_in = d;
        acc = !a_busy_m;
        if (acc && rd) qa.push_back(ma[ad]);
        if (acc && ld) ma[ad] = d;
        if (a_busy_m) begin
            ma[a_clr_cnt] = 16'h0;
            a_clr_cnt++;
            if (a_clr_cnt == 256) a_busy_m = 1'b0;
        end
        @(posedge clk); #1;
        a_load = 1'b0; a_read = 1'b0;
        chk("a_busy", {31'h0, a_busy}, {31'h0, a_busy_m});
        chk("a_valid", {31'h0, a_valid}, {31'h0, acc && rd});
        if (a_valid) begin
            if (qa.size() == 0) chk("a_unexpected_read", 32'h1, 32'h0);
            else begin
                a_last = qa.pop_front();
                chk("a_rdata", {16'h0, a_out}, {16'h0, a_last});
            end
        end else begin
            chk("a_hold", {16'h0, a_out}, {16'h0, a_last});
        end
    endtask

    task automatic rst_b(input int n);
        b_resetn = 1'b0; b_load = 1'b0; b_read = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("b_rst_out", {24'h0, b_out}, 32'h0);
            chk("b_rst_valid", {31'h0, b_valid}, 32'h0);
            chk("b_rst_busy", {31'h0, b_busy}, 32'h0);
        end
        b_resetn = 1'b1;
        b_last   = 8'h0;
        qb.delete();
    endtask

    task automatic cyc_b(input bit ld, input bit rd, input logic [3:0] ad, input logic [7:0] d);
        if (rd) qb.push_back(ld ? d : mb[ad]);
        if (ld) mb[ad] = d;
        b_load = ld; b_read = rd; b_addr = ad; b_in = d;
        @(posedge clk); #1;
        b_load = 1'b0; b_read = 1'b0;
        chk("b_busy", {31'h0, b_busy}, 32'h0);
        chk("b_valid", {31'h0, b_valid}, {31'h0, rd});
        if (b_valid) begin
            if (qb.size() == 0) chk("b_unexpected_read", 32'h1, 32'h0);
            else begin
                b_last = qb.pop_front();
                chk("b_rdata", {24'h0, b_out}, {24'h0, b_last});
            end
        end else begin
            chk("b_hold", {24'h0, b_out}, {24'h0, b_last});
        end
    endtask

    initial begin
        int busy_cycles;
        a_resetn = 1'b0; a_load = 1'b0; a_read = 1'b0; a_addr = '0; a_in = '0;
        b_resetn = 1'b0; b_load = 1'b0; b_read = 1'b0; b_addr = '0; b_in = '0;
        a_busy_m = 1'b1; a_clr_cnt = 0; a_last = '0;
        for (int i = 0; i < 256; i++) ma[i] = 16'hxxxx;
        for (int i = 0; i < 16; i++) mb[i] = 8'hxx;

        // Clear after reset: busy for exactly 256 cycles, then zeros read back
        rst_a(2);
        busy_cycles = 0;
        while (a_busy_m && busy_cycles < 300) begin
            cyc_a(0, 0, 8'h0, 16'h0);
            busy_cycles++;
        end
        chk("a_clear_len", busy_cycles, 256);
        cyc_a(0, 1, 8'h00, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);
        cyc_a(0, 1, 8'h7F, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);
        cyc_a(0, 1, 8'hFF, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);

        // Write then read next cycle, then out holds
        cyc_a(1, 0, 8'h05, 16'hBEEF);
        cyc_a(0, 1, 8'h05, 16'h0);
        repeat (3) cyc_a(0, 0, 8'h00, 16'h0);

        // Same-address collision, read-first
        cyc_a(1, 0, 8'h10, 16'h1111);
        cyc_a(1, 1, 8'h10, 16'h2222);
        cyc_a(0, 1, 8'h10, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);

        // Back-to-back reads to different words
        cyc_a(0, 1, 8'h05, 16'h0);
        cyc_a(0, 1, 8'h10, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);

        // Access while busy is dropped
        rst_a(1);
        repeat (10) cyc_a(0, 0, 8'h0, 16'h0);
        cyc_a(1, 1, 8'h20, 16'hAAAA);
        while (a_busy_m) cyc_a(0, 0, 8'h0, 16'h0);
        cyc_a(0, 1, 8'h20, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);

        // Reset in the middle of a clear restarts it from address 0
        cyc_a(1, 0, 8'h80, 16'h1234);
        cyc_a(0, 1, 8'h80, 16'h0);
        rst_a(3);
        repeat (50) cyc_a(0, 0, 8'h0, 16'h0);
        rst_a(2);
        busy_cycles = 0;
        while (a_busy_m && busy_cycles < 300) begin
            cyc_a(0, 0, 8'h0, 16'h0);
            busy_cycles++;
        end
        chk("a_reclear_len", busy_cycles, 256);
        cyc_a(0, 1, 8'h80, 16'h0);
        cyc_a(0, 0, 8'h00, 16'h0);

        // Small write-first build without clear: ready right after reset
        rst_b(2);
        for (int i = 0; i < 16; i++) cyc_b(1, 0, i[3:0], i[7:0] ^ 8'h5A);
        cyc_b(0, 0, 4'h0, 8'h0);
        for (int i = 0; i < 16; i++) cyc_b(0, 1, i[3:0], 8'h0);
        cyc_b(0, 0, 4'h0, 8'h0);
        cyc_b(1, 0, 4'h3, 8'h11);
        cyc_b(1, 1, 4'h3, 8'h22);
        cyc_b(0, 1, 4'h3, 8'h0);
        repeat (2) cyc_b(0, 0, 4'h0, 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
